user_input_cond: RTL and testbench

- Input-conditioning stage directly upstream of the control FSM; produces the FSM's 3-bit user_input code.
- Synchronises a raw, asynchronous 3-bit user code into clk and debounces it.
- Each new stable code is committed once, with a one-cycle valid strobe.
- Its own state machine fully decodes every encoding, so it cannot lock up in an undefined state.

---
 rtl/uic_pkg.sv | 13 +
 rtl/uic_sync.sv | 29 ++
 rtl/user_input_cond.sv | 119 +++++++++++
 tb/tb_user_input_cond.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uic_pkg.sv
// Shared types for the user-input conditioning stage.
package uic_pkg;

    localparam int UIC_STATE_W = 2;

    typedef enum logic [UIC_STATE_W-1:0] {
        UIC_IDLE    = 2'b00,
        UIC_SETTLE  = 2'b01,
        UIC_COMMIT  = 2'b10,
        UIC_ILLEGAL = 2'b11
    } uic_state_e;

endpackage

// File: rtl/uic_sync.sv
// WIDTH x SYNC_STAGES metastability synchroniser, asynchronously reset to 0.
module uic_sync #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/user_input_cond.sv
// Synchronise, debounce and commit the raw user code for the control FSM.
// Optional glitch counter output enabled by defining UIC_GLITCH_CNT_EN.
module user_input_cond
    import uic_pkg::*;
#(
    parameter  int WIDTH           = 3,
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             enable,
    output logic [WIDTH-1:0] cmd_out,
    output logic             cmd_valid,
    output logic             busy
`ifdef UIC_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_cnt
`endif
);

    logic [WIDTH-1:0] sync_q;
    uic_state_e       state, state_nxt;
    logic [WIDTH-1:0] cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] cmd_nxt;

    uic_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (raw_in),
        .q    (sync_q)
    );

`ifdef UIC_GLITCH_CNT_EN
    logic glitch_evt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= UIC_IDLE;
            cand    <= '0;
            cnt     <= '0;
            cmd_out <= '0;
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            cnt     <= cnt_nxt;
            cmd_out <= cmd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        cmd_nxt   = cmd_out;
`ifdef UIC_GLITCH_CNT_EN
        glitch_evt = 1'b0;
`endif
        case (state)
            UIC_IDLE: begin
                if (enable && (sync_q != cmd_out)) begin
                    state_nxt = UIC_SETTLE;
                    cand_nxt  = sync_q;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = UIC_IDLE;
                end
            end
            UIC_SETTLE: begin
                // enable beats glitch beats commit when they coincide
                if (!enable) begin
                    state_nxt = UIC_IDLE;
                    cnt_nxt   = '0;
                end else if (sync_q != cand) begin
                    state_nxt = UIC_IDLE;
                    cnt_nxt   = '0;
`ifdef UIC_GLITCH_CNT_EN
                    glitch_evt = 1'b1;
`endif
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_nxt = UIC_COMMIT;
                    cmd_nxt   = cand;
                end else begin
                    state_nxt = UIC_SETTLE;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            UIC_COMMIT: begin
                state_nxt = UIC_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = UIC_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign cmd_valid = (state == UIC_COMMIT);
    assign busy      = (state != UIC_IDLE);

`ifdef UIC_GLITCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_user_input_cond.sv
// Randomised and directed bench for user_input_cond against a phase-based reference model.
module tb_user_input_cond;
    import uic_pkg::*;

    localparam int WIDTH = 3;
    localparam int S     = 2;
    localparam int D     = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] raw_in = '0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] cmd_out;
    logic             cmd_valid;
    logic             busy;
`ifdef UIC_GLITCH_CNT_EN
    logic [7:0]       glitch_cnt;
`endif

    always #5 clk = ~clk;

    user_input_cond #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (raw_in),
        .enable   (enable),
        .cmd_out  (cmd_out),
        .cmd_valid(cmd_valid),
        .busy     (busy)
`ifdef UIC_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: phase 0 = waiting, 1..D = k-th cycle of a debounce
    // attempt, D+1 = strobe cycle; m_ill marks a forced illegal cycle.
    logic [WIDTH-1:0] m_sync [S];
    int               m_phase;
    logic [WIDTH-1:0] m_cand;
    logic [WIDTH-1:0] m_cmd;
    int               m_glitch;
    bit               m_ill;
    int               edge_no = 0;

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_sync[i] = '0;
        m_phase = 0;
        m_cand  = '0;
        m_cmd   = '0;
        m_glitch = 0;
        m_ill   = 0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] seen;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = m_sync[S-1];
        if (m_ill) begin
            m_ill   = 0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (enable && seen != m_cmd) begin
                m_phase = 1;
                m_cand  = seen;
            end
        end else if (m_phase <= D) begin
            if (!enable) m_phase = 0;
            else if (seen != m_cand) begin
                m_phase = 0;
                if (m_glitch < 255) m_glitch++;
            end else if (m_phase == D) begin
                m_phase = D + 1;
                m_cmd   = m_cand;
            end else m_phase++;
        end else begin
            m_phase = 0;
        end
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = raw_in;
    endtask

    task automatic compare_outputs();
        check("cmd_out", 32'(cmd_out), 32'(m_cmd));
        check("cmd_valid", 32'(cmd_valid), 32'(m_phase == D + 1 && !m_ill));
        check("busy", 32'(busy), 32'(m_phase != 0 || m_ill));
`ifdef UIC_GLITCH_CNT_EN
        check("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
`endif
    endtask

    task automatic drive(input logic [WIDTH-1:0] r, input logic e);
        @(negedge clk);
        raw_in = r;
        enable = e;
        @(posedge clk);
        edge_no++;
        model_edge();
        #1 compare_outputs();
    endtask

    initial begin
        int t0, lat, busy_n, pulses, hold;
        logic [WIDTH-1:0] r, a;
        logic e;

        model_reset();
        #1 compare_outputs();
        check("reset_cmd_out", 32'(cmd_out), 32'd0);
        drive('0, 1'b0);
        drive('0, 1'b0);
        rst_n = 1'b1;

        // Idle with zero input: never busy, never strobes
        pulses = 0;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            drive('0, 1'b1);
            if (cmd_valid) pulses++;
            if (busy) busy_n++;
        end
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_busy", 32'(busy_n), 32'd0);

        // 0 -> 101: one strobe after edge t+S+D
        drive(3'b101, 1'b1);
        t0 = edge_no;
        lat = -1; busy_n = 0; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            drive(3'b101, 1'b1);
            if (busy && lat < 0) busy_n++;
            if (cmd_valid) begin
                pulses++;
                if (lat < 0) lat = edge_no - t0;
            end
        end
        check("latency_101", 32'(lat), 32'(S + D));
        check("pulses_101", 32'(pulses), 32'd1);
        check("busy_cycles_101", 32'(busy_n), 32'(D + 1));
        check("cmd_101", 32'(cmd_out), 32'(3'b101));

        // Same code again: no attempt
        for (int i = 0; i < 10; i++) drive(3'b101, 1'b1);

        // Short 011 burst then back: glitch, no commit
        for (int i = 0; i < 10; i++) drive(3'b011, 1'b1);
        for (int i = 0; i < 10; i++) drive(3'b101, 1'b1);
        check("cmd_after_glitch", 32'(cmd_out), 32'(3'b101));

        // 110 with enable dropped on the commit cycle
        for (int i = 0; i < 40 && m_phase != D; i++) drive(3'b110, 1'b1);
        check("reached_cnt15", 32'(m_phase), 32'(D));
        drive(3'b110, 1'b0);
        check("no_commit_on_drop", 32'(cmd_out), 32'(3'b101));
        for (int i = 0; i < 3; i++) drive(3'b110, 1'b0);
        for (int i = 0; i < 30; i++) drive(3'b110, 1'b1);
        check("cmd_110", 32'(cmd_out), 32'(3'b110));

        // Forced illegal encoding returns to IDLE, cmd held
        force dut.state = UIC_ILLEGAL;
        #1 release dut.state;
        m_ill = 1;
        check("illegal_busy", 32'(busy), 32'd1);
        check("illegal_valid", 32'(cmd_valid), 32'd0);
        drive(3'b110, 1'b1);
        check("illegal_to_idle", 32'(busy), 32'd0);
        check("illegal_cmd_held", 32'(cmd_out), 32'(3'b110));

        // Reset asserted mid-attempt (cnt=8) on 0->111
        for (int i = 0; i < 40 && m_phase != 9; i++) drive(3'b111, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_cmd", 32'(cmd_out), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(cmd_valid), 32'd0);
        drive(3'b111, 1'b1);
        drive(3'b111, 1'b1);
        rst_n = 1'b1;
        drive(3'b111, 1'b1);
        t0 = edge_no;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            drive(3'b111, 1'b1);
            if (cmd_valid && lat < 0) lat = edge_no - t0;
        end
        check("latency_after_rst", 32'(lat), 32'(S + D));
        check("cmd_111", 32'(cmd_out), 32'(3'b111));

`ifdef UIC_GLITCH_CNT_EN
        // Drive enough glitches to saturate the counter
        a = cmd_out;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) drive(~a, 1'b1);
            for (int k = 0; k < 4; k++) drive(a, 1'b1);
        end
        check("glitch_saturated", 32'(glitch_cnt), 32'hFF);
`endif

        // Random codes, hold lengths and enable drops
        r = '0; e = 1'b1; hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                r = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                hold = $urandom_range(1, 30);
            end
            hold--;
            e = ($urandom_range(0, 19) != 0);
            drive(r, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
